// File: rtl/issue_stage.sv
// Issue stage: skid-buffered decode intake, operand read with execute forwarding,
// load-use interlock, data-memory request launch and the execute input register.
module issue_stage #(
    parameter int PW    = 192,
    parameter int DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [PW-1:0] dec_payload,
    input  logic [4:0]    dec_rs1,
    input  logic [4:0]    dec_rs2,
    input  logic [4:0]    dec_rd,
    input  logic          dec_rden1,
    input  logic          dec_rden2,
    input  logic          dec_wren,
    input  logic          dec_load,
    input  logic          dec_store,
    input  logic [1:0]    dec_size,
    input  logic [31:0]   dec_imm,
    output logic [4:0]    rf_raddr1,
    output logic [4:0]    rf_raddr2,
    input  logic [31:0]   rf_rdata1,
    input  logic [31:0]   rf_rdata2,
    input  logic          fwd_wren,
    input  logic [4:0]    fwd_waddr,
    input  logic [31:0]   fwd_wdata,
    input  logic          ex_stall,
    input  logic          ex_clear,
    output logic          ex_valid,
    output logic [PW-1:0] ex_payload,
    output logic [31:0]   ex_rdata1,
    output logic [31:0]   ex_rdata2,
    output logic          ex_exc,
    output logic [3:0]    ex_ecause,
    output logic          mem_valid,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PW-1:0] payload;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic          rden1;
        logic          rden2;
        logic          wren;
        logic          load;
        logic          store;
        logic [1:0]    size;
        logic [31:0]   imm;
    } entry_t;

    entry_t         fifo_q [DEPTH];
    entry_t         din;
    entry_t         head;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           head_vld;
    logic           push;
    logic           issue;
    logic           hazard;
    logic           ex_load;
    logic [4:0]     ex_rd;
    logic [31:0]    op1;
    logic [31:0]    op2;
    logic [31:0]    ea;
    logic           is_mem;
    logic           mis;
    logic           exc;
    logic [3:0]     ecause;
    logic [3:0]     strb_base;

    function automatic logic [31:0] resolve(
        input logic        en,
        input logic [4:0]  rs,
        input logic [31:0] rdata,
        input logic        fen,
        input logic [4:0]  faddr,
        input logic [31:0] fdata
    );
        if (!en || rs == 5'd0)
            return 32'd0;
        if (fen && faddr == rs)
            return fdata;
        return rdata;
    endfunction

    assign din = '{
        payload: dec_payload,
        rs1:     dec_rs1,
        rs2:     dec_rs2,
        rd:      dec_rd,
        rden1:   dec_rden1,
        rden2:   dec_rden2,
        wren:    dec_wren,
        load:    dec_load,
        store:   dec_store,
        size:    dec_size,
        imm:     dec_imm
    };

    assign head_vld  = (count != '0);
    assign head      = head_vld ? fifo_q[rd_ptr] : '0;
    assign dec_ready = (count < CW'(DEPTH));
    assign push      = dec_valid & dec_ready & ~ex_clear;
    assign rf_raddr1 = head.rs1;
    assign rf_raddr2 = head.rs2;

    assign op1 = resolve(head.rden1, head.rs1, rf_rdata1,
                         fwd_wren, fwd_waddr, fwd_wdata);
    assign op2 = resolve(head.rden2, head.rs2, rf_rdata2,
                         fwd_wren, fwd_waddr, fwd_wdata);

    // A load without writeback cannot create a dependency, so the tag needs wren.
    assign hazard = ex_valid & ex_load & (ex_rd != 5'd0) &
                    ((head.rden1 & (head.rs1 == ex_rd)) |
                     (head.rden2 & (head.rs2 == ex_rd)));

    assign issue = head_vld & ~ex_stall & ~hazard & ~ex_clear;

    assign ea     = op1 + head.imm;
    assign is_mem = head.load | head.store;
    assign mis    = ((head.size == 2'd1) & ea[0]) |
                    (head.size[1] & (ea[1:0] != 2'b00));
    assign exc    = is_mem & mis;
    assign ecause = exc ? (head.store ? 4'd6 : 4'd4) : 4'd0;

    always_comb begin
        strb_base = 4'hF;
        unique case (1'b1)
            head.size == 2'd0: strb_base = 4'h1;
            head.size == 2'd1: strb_base = 4'h3;
            default:           strb_base = 4'hF;
        endcase
    end

    assign mem_valid = issue & is_mem & ~mis;
    assign mem_addr  = {ea[31:2], 2'b00};
    assign mem_wdata = op2 << {ea[1:0], 3'b000};
    assign mem_wstrb = (mem_valid & head.store) ? (strb_base << ea[1:0]) : 4'h0;

    always_ff @(posedge clock) begin
        if (push)
            fifo_q[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (ex_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (issue)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(issue);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_payload <= '0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_exc     <= 1'b0;
            ex_ecause  <= '0;
            ex_load    <= 1'b0;
            ex_rd      <= '0;
        end else if (ex_clear) begin
            ex_valid <= 1'b0;
            ex_exc   <= 1'b0;
            ex_load  <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid <= issue;
            ex_exc   <= issue & exc;
            ex_load  <= issue & head.load & head.wren;
            if (issue) begin
                ex_payload <= head.payload;
                ex_rdata1  <= op1;
                ex_rdata2  <= op2;
                ex_ecause  <= ecause;
                ex_rd      <= head.rd;
            end
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: scoreboard queues for execute-register
// contents and memory requests, plus cycle-exact checks on stalls and flushes.
module tb_issue_stage;

    localparam int PW = 192;

    logic          clock;
    logic          reset;
    logic          dec_valid;
    logic          dec_ready;
    logic [PW-1:0] dec_payload;
    logic [4:0]    dec_rs1, dec_rs2, dec_rd;
    logic          dec_rden1, dec_rden2, dec_wren;
    logic          dec_load, dec_store;
    logic [1:0]    dec_size;
    logic [31:0]   dec_imm;
    logic [4:0]    rf_raddr1, rf_raddr2;
    logic [31:0]   rf_rdata1, rf_rdata2;
    logic          fwd_wren;
    logic [4:0]    fwd_waddr;
    logic [31:0]   fwd_wdata;
    logic          ex_stall, ex_clear;
    logic          ex_valid;
    logic [PW-1:0] ex_payload;
    logic [31:0]   ex_rdata1, ex_rdata2;
    logic          ex_exc;
    logic [3:0]    ex_ecause;
    logic          mem_valid;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;

    logic [31:0]   rf [32];

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    issue_stage #(.PW(PW), .DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_payload(dec_payload),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_rden1(dec_rden1), .dec_rden2(dec_rden2), .dec_wren(dec_wren),
        .dec_load(dec_load), .dec_store(dec_store),
        .dec_size(dec_size), .dec_imm(dec_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_wren(fwd_wren), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .ex_stall(ex_stall), .ex_clear(ex_clear),
        .ex_valid(ex_valid), .ex_payload(ex_payload),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_exc(ex_exc), .ex_ecause(ex_ecause),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] id;
        logic [4:0]  rs1, rs2, rd;
        logic        e1, e2, we, ld, st;
        logic [1:0]  sz;
        logic [31:0] imm;
    } ins_t;

    typedef struct {
        logic [PW-1:0] pl;
        logic [31:0]   r1, r2;
        logic          exc;
        logic [3:0]    ec;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
    } mexp_t;

    exp_t  exq[$];
    mexp_t mq[$];
    int    ncmp = 0;
    int    nbad = 0;
    logic  stall_e;

    task automatic chk(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(
        input logic [31:0] id, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic e1, input logic e2, input logic we,
        input logic ld, input logic st, input logic [1:0] sz,
        input logic [31:0] imm);
        ins_t i;
        i.id = id; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.e1 = e1; i.e2 = e2; i.we = we; i.ld = ld; i.st = st;
        i.sz = sz; i.imm = imm;
        return i;
    endfunction

    function automatic logic [31:0] opnd(input logic en, input logic [4:0] rs);
        if (!en || rs == 5'd0) return 32'd0;
        if (fwd_wren && fwd_waddr == rs) return fwd_wdata;
        return rf[rs];
    endfunction

    task automatic book(input ins_t i);
        exp_t        e;
        mexp_t       m;
        logic [31:0] o1, o2, ea;
        logic [3:0]  base;
        logic        mis;
        o1  = opnd(i.e1, i.rs1);
        o2  = opnd(i.e2, i.rs2);
        ea  = o1 + i.imm;
        mis = (i.ld || i.st) &&
              ((i.sz == 2'd1 && ea[0]) || (i.sz == 2'd2 && ea[1:0] != 2'b00));
        e.pl  = PW'(i.id);
        e.r1  = o1;
        e.r2  = o2;
        e.exc = mis;
        e.ec  = mis ? (i.st ? 4'd6 : 4'd4) : 4'd0;
        exq.push_back(e);
        if ((i.ld || i.st) && !mis) begin
            base    = (i.sz == 2'd0) ? 4'h1 : (i.sz == 2'd1) ? 4'h3 : 4'hF;
            m.addr  = {ea[31:2], 2'b00};
            m.wdata = o2 << (8 * ea[1:0]);
            m.strb  = i.st ? 4'(base << ea[1:0]) : 4'h0;
            mq.push_back(m);
        end
    endtask

    task automatic offer(input ins_t i);
        dec_valid   = 1'b1;
        dec_payload = PW'(i.id);
        dec_rs1 = i.rs1; dec_rs2 = i.rs2; dec_rd = i.rd;
        dec_rden1 = i.e1; dec_rden2 = i.e2; dec_wren = i.we;
        dec_load = i.ld; dec_store = i.st;
        dec_size = i.sz; dec_imm = i.imm;
    endtask

    task automatic send(input ins_t i, input bit expect_it);
        int n = 0;
        offer(i);
        while (!dec_ready && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 40) chk("accept_timeout", 1, 0);
        if (expect_it) book(i);
        @(posedge clock); #1;
        dec_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clock);
        #1;
    endtask

    always @(posedge clock) stall_e <= ex_stall;

    always @(negedge clock) begin
        if (!reset) begin
            if (ex_valid && !stall_e) begin
                if (exq.size() == 0) begin
                    chk("ex_unexpected", ex_payload, '0);
                end else begin
                    exp_t e;
                    e = exq.pop_front();
                    chk("ex_payload", ex_payload, e.pl);
                    chk("ex_rdata1", PW'(ex_rdata1), PW'(e.r1));
                    chk("ex_rdata2", PW'(ex_rdata2), PW'(e.r2));
                    chk("ex_exc", PW'(ex_exc), PW'(e.exc));
                    chk("ex_ecause", PW'(ex_ecause), PW'(e.ec));
                end
            end
            if (mem_valid) begin
                if (mq.size() == 0) begin
                    chk("mem_unexpected", PW'(mem_valid), 0);
                end else begin
                    mexp_t m;
                    m = mq.pop_front();
                    chk("mem_addr", PW'(mem_addr), PW'(m.addr));
                    chk("mem_wdata", PW'(mem_wdata), PW'(m.wdata));
                    chk("mem_wstrb", PW'(mem_wstrb), PW'(m.strb));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'h1111_0000 + k;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h0000_1000;
        rf[7] = 32'h0000_1000;
        rf[8] = 32'h0000_ABCD;
        reset = 1'b1;
        dec_valid = 0; dec_payload = '0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_rden1 = 0; dec_rden2 = 0; dec_wren = 0;
        dec_load = 0; dec_store = 0; dec_size = 0; dec_imm = 0;
        fwd_wren = 0; fwd_waddr = 0; fwd_wdata = 0;
        ex_stall = 0; ex_clear = 0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_dec_ready", PW'(dec_ready), 1);
        chk("rst_ex_valid", PW'(ex_valid), 0);
        chk("rst_ex_exc", PW'(ex_exc), 0);
        chk("rst_ex_ecause", PW'(ex_ecause), 0);
        chk("rst_ex_payload", ex_payload, '0);
        chk("rst_mem_valid", PW'(mem_valid), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // back-to-back independent ALU ops
        send(mk(32'h11, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        send(mk(32'h12, 5'd3, 5'd4, 5'd9, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        @(negedge clock);
        chk("t1_ex_valid_a", PW'(ex_valid), 1);
        chk("t1_ready_a", PW'(dec_ready), 1);
        send(mk(32'h13, 5'd0, 5'd5, 5'd10, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        @(negedge clock);
        chk("t1_ex_valid_b", PW'(ex_valid), 1);
        chk("t1_ready_b", PW'(dec_ready), 1);
        send(mk(32'h14, 5'd6, 5'd7, 5'd11, 1, 0, 1, 0, 0, 2'd0, 0), 1);
        @(negedge clock);
        chk("t1_ex_valid_c", PW'(ex_valid), 1);
        chk("t1_ready_c", PW'(dec_ready), 1);
        drain();

        // load-use: one bubble, then forwarded operand
        fwd_wren = 1; fwd_waddr = 5'd5; fwd_wdata = 32'hCAFE_0005;
        send(mk(32'h21, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0, 2'd2, 32'd4), 1);
        send(mk(32'h22, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        @(negedge clock);
        chk("t2_lw_in_ex", ex_payload, PW'(32'h21));
        @(negedge clock);
        chk("t2_bubble", PW'(ex_valid), 0);
        @(negedge clock);
        chk("t2_add_valid", PW'(ex_valid), 1);
        chk("t2_add_fwd", PW'(ex_rdata1), PW'(32'hCAFE_0005));
        fwd_wren = 0;
        drain();

        // aligned stores: SH at +2, SB at +3
        send(mk(32'h31, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd1, 32'd2), 1);
        @(negedge clock);
        chk("t3_mem_valid", PW'(mem_valid), 1);
        chk("t3_mem_addr", PW'(mem_addr), PW'(32'h1000));
        chk("t3_mem_wstrb", PW'(mem_wstrb), PW'(4'hC));
        chk("t3_mem_wdata", PW'(mem_wdata), PW'(32'hABCD_0000));
        send(mk(32'h32, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd0, 32'd3), 1);
        drain();

        // misaligned load then misaligned store
        send(mk(32'h41, 5'd7, 5'd0, 5'd9, 1, 0, 1, 1, 0, 2'd2, 32'd2), 1);
        @(negedge clock);
        chk("t4_lw_no_mem", PW'(mem_valid), 0);
        send(mk(32'h42, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd1, 32'd1), 1);
        @(negedge clock);
        chk("t4_lw_exc", PW'(ex_exc), 1);
        chk("t4_lw_cause", PW'(ex_ecause), 4);
        chk("t4_sh_no_mem", PW'(mem_valid), 0);
        @(negedge clock);
        chk("t4_sh_exc", PW'(ex_exc), 1);
        chk("t4_sh_cause", PW'(ex_ecause), 6);
        drain();

        // execute stall for 4 cycles while decode keeps offering
        send(mk(32'h51, 5'd1, 5'd2, 5'd12, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        @(posedge clock); #1;
        ex_stall = 1;
        send(mk(32'h52, 5'd2, 5'd3, 5'd13, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        send(mk(32'h53, 5'd3, 5'd4, 5'd14, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        offer(mk(32'h54, 5'd4, 5'd5, 5'd15, 1, 1, 1, 0, 0, 2'd0, 0));
        chk("t5_full", PW'(dec_ready), 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            @(negedge clock);
            chk("t5_hold_valid", PW'(ex_valid), 1);
            chk("t5_hold_payload", ex_payload, PW'(32'h51));
            chk("t5_hold_ready", PW'(dec_ready), 0);
        end
        ex_stall = 0;
        #1;
        chk("t5_full_on_pop", PW'(dec_ready), 0);
        @(posedge clock); #1;
        chk("t5_ready_back", PW'(dec_ready), 1);
        book(mk(32'h54, 5'd4, 5'd5, 5'd15, 1, 1, 1, 0, 0, 2'd0, 0));
        @(posedge clock); #1;
        dec_valid = 0;
        drain();

        // flush with two buffered entries and one in execute
        send(mk(32'h60, 5'd1, 5'd2, 5'd16, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        @(posedge clock); #1;
        ex_stall = 1;
        send(mk(32'h61, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd2, 0), 0);
        send(mk(32'h62, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd2, 32'd4), 0);
        chk("t6_pre_valid", PW'(ex_valid), 1);
        ex_clear = 1; ex_stall = 0;
        offer(mk(32'h63, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd2, 32'd8));
        @(negedge clock);
        chk("t6_clr_no_mem", PW'(mem_valid), 0);
        @(posedge clock); #1;
        ex_clear = 0; dec_valid = 0;
        chk("t6_count0", PW'(dec_ready), 1);
        chk("t6_ex_valid", PW'(ex_valid), 0);
        chk("t6_empty_raddr", PW'(rf_raddr1), 0);
        @(posedge clock); #1;
        chk("t6_still_idle", PW'(ex_valid), 0);
        send(mk(32'h64, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 1, 2'd2, 32'd4), 1);
        drain();

        // asynchronous reset in mid-operation
        send(mk(32'h71, 5'd1, 5'd2, 5'd17, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        @(posedge clock); #1;
        ex_stall = 1;
        send(mk(32'h72, 5'd2, 5'd3, 5'd18, 1, 1, 1, 0, 0, 2'd0, 0), 0);
        send(mk(32'h73, 5'd3, 5'd4, 5'd19, 1, 1, 1, 0, 0, 2'd0, 0), 0);
        @(negedge clock);
        #2;
        reset = 1;
        #1;
        chk("ar_ex_valid", PW'(ex_valid), 0);
        chk("ar_dec_ready", PW'(dec_ready), 1);
        chk("ar_ex_payload", ex_payload, '0);
        chk("ar_ex_rdata1", PW'(ex_rdata1), 0);
        #1;
        reset = 0; ex_stall = 0;
        @(posedge clock); #1;
        send(mk(32'h74, 5'd1, 5'd2, 5'd20, 1, 1, 1, 0, 0, 2'd0, 0), 1);
        drain();

        chk("sb_ex_left", PW'(exq.size()), 0);
        chk("sb_mem_left", PW'(mq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
